// File: rtl/tm1638_pkg.sv
// Shared TM1638 protocol constants: command classes, command bit positions,
// sizes and the responder state encoding.
package tm1638_pkg;

    localparam logic [1:0] CMD_DATA = 2'b01;
    localparam logic [1:0] CMD_DISP = 2'b10;
    localparam logic [1:0] CMD_ADDR = 2'b11;

    localparam int unsigned DATA_READ_BIT  = 1;
    localparam int unsigned DATA_FIXED_BIT = 2;
    localparam int unsigned DISP_ON_BIT    = 3;

    localparam int unsigned KEY_BYTES = 4;
    localparam int unsigned RAM_BYTES = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WRITE,
        S_READ,
        S_IGNORE
    } tm1638_state_t;

endpackage

// File: rtl/tm1638_pin_sync.sv
// Multi-flop synchronizer for one asynchronous pin with rise/fall strobes
// derived from the synchronized level.
module tm1638_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/tm1638_responder.sv
// Device-side TM1638 protocol responder: decodes host commands into a 16-byte
// display RAM and display control, and shifts key-scan bytes back on DIO.
module tm1638_responder
    import tm1638_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_tm1638_clk,
    input  logic                     i_tm1638_stb,
    inout  wire                      io_tm1638_data,
    input  logic [8*KEY_BYTES-1:0]   i_key_bytes,
    output logic [8*RAM_BYTES-1:0]   o_display_ram,
    output logic                     o_wr_en,
    output logic [3:0]               o_wr_addr,
    output logic [7:0]               o_wr_data,
    output logic                     o_display_on,
    output logic [2:0]               o_brightness,
    output logic                     o_frame_err,
    output logic                     o_busy
);

    logic clk_lvl_unused, clk_rise, clk_fall;
    logic stb_lvl, stb_rise_unused, stb_fall;
    logic dio_lvl, dio_rise_unused, dio_fall_unused;

    tm1638_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_clk (
        .clk_i(i_clk), .rst_i(i_rst), .pin_i(i_tm1638_clk),
        .level_o(clk_lvl_unused), .rise_o(clk_rise), .fall_o(clk_fall)
    );

    tm1638_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_stb (
        .clk_i(i_clk), .rst_i(i_rst), .pin_i(i_tm1638_stb),
        .level_o(stb_lvl), .rise_o(stb_rise_unused), .fall_o(stb_fall)
    );

    tm1638_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_dio (
        .clk_i(i_clk), .rst_i(i_rst), .pin_i(io_tm1638_data),
        .level_o(dio_lvl), .rise_o(dio_rise_unused), .fall_o(dio_fall_unused)
    );

    tm1638_state_t                  state_q, state_d;
    logic [2:0]                     bit_cnt_q, bit_cnt_d;
    logic [1:0]                     byte_cnt_q, byte_cnt_d;
    logic [7:0]                     shift_q, shift_d;
    logic [3:0]                     addr_q, addr_d;
    logic                           fixed_q, fixed_d;
    logic [RAM_BYTES-1:0][7:0]      ram_q, ram_d;
    logic                           disp_on_q, disp_on_d;
    logic [2:0]                     bright_q, bright_d;
    logic [8*KEY_BYTES-1:0]         key_q, key_d;
    logic                           dio_low_q, dio_low_d;
    logic                           wr_en_q, wr_en_d;
    logic [3:0]                     wr_addr_q, wr_addr_d;
    logic [7:0]                     wr_data_q, wr_data_d;
    logic                           frame_err_q, frame_err_d;
    logic [7:0]                     rx_byte;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            fixed_q     <= 1'b0;
            ram_q       <= '0;
            disp_on_q   <= 1'b0;
            bright_q    <= '0;
            key_q       <= '0;
            dio_low_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            fixed_q     <= fixed_d;
            ram_q       <= ram_d;
            disp_on_q   <= disp_on_d;
            bright_q    <= bright_d;
            key_q       <= key_d;
            dio_low_q   <= dio_low_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    // LSB-first: each sampled bit enters at the top and shifts down.
    assign rx_byte = {dio_lvl, shift_q[7:1]};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        fixed_d     = fixed_q;
        ram_d       = ram_q;
        disp_on_d   = disp_on_q;
        bright_d    = bright_q;
        key_d       = key_q;
        dio_low_d   = dio_low_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;

        // STB high outranks any CLK edge seen in the same cycle.
        if (stb_lvl) begin
            state_d   = S_IDLE;
            dio_low_d = 1'b0;
            if ((state_q == S_CMD || state_q == S_WRITE) && bit_cnt_q != 3'd0) begin
                frame_err_d = 1'b1;
                bit_cnt_d   = '0;
            end
        end else if (stb_fall) begin
            bit_cnt_d = '0;
            state_d   = S_CMD;
        end else begin
            case (state_q)
                S_CMD: begin
                    if (clk_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = S_IGNORE;
                            case (rx_byte[7:6])
                                CMD_DATA: begin
                                    fixed_d = rx_byte[DATA_FIXED_BIT];
                                    if (rx_byte[DATA_READ_BIT]) begin
                                        key_d      = i_key_bytes;
                                        byte_cnt_d = '0;
                                        state_d    = S_READ;
                                    end
                                end
                                CMD_DISP: begin
                                    disp_on_d = rx_byte[DISP_ON_BIT];
                                    bright_d  = rx_byte[2:0];
                                end
                                CMD_ADDR: begin
                                    addr_d  = rx_byte[3:0];
                                    state_d = S_WRITE;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                S_WRITE: begin
                    if (clk_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            ram_d[addr_q] = rx_byte;
                            wr_en_d       = 1'b1;
                            wr_addr_d     = addr_q;
                            wr_data_d     = rx_byte;
                            if (!fixed_q) addr_d = addr_q + 4'd1;
                        end
                    end
                end
                S_READ: begin
                    if (clk_fall) begin
                        dio_low_d = ~key_q[{byte_cnt_q, bit_cnt_q}];
                    end else if (clk_rise) begin
                        {byte_cnt_d, bit_cnt_d} = {byte_cnt_q, bit_cnt_q} + 5'd1;
                        if ({byte_cnt_q, bit_cnt_q} == 5'd31) begin
                            dio_low_d = 1'b0;
                            state_d   = S_IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_tm1638_data = dio_low_q ? 1'b0 : 1'bz;

    assign o_display_ram = ram_q;
    assign o_wr_en       = wr_en_q;
    assign o_wr_addr     = wr_addr_q;
    assign o_wr_data     = wr_data_q;
    assign o_display_on  = disp_on_q;
    assign o_brightness  = bright_q;
    assign o_frame_err   = frame_err_q;
    assign o_busy        = ~stb_lvl;

endmodule

// File: tb/tb_tm1638_responder.sv
// Directed bench for tm1638_responder acting as a TM1638 host over STB/CLK/DIO.
module tb_tm1638_responder;

    localparam int HALF = 8;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         host_clk = 1'b1;
    logic         host_stb = 1'b1;
    logic         host_low = 1'b0;
    logic [31:0]  i_key_bytes = '0;
    logic [127:0] o_display_ram;
    logic         o_wr_en;
    logic [3:0]   o_wr_addr;
    logic [7:0]   o_wr_data;
    logic         o_display_on;
    logic [2:0]   o_brightness;
    logic         o_frame_err;
    logic         o_busy;
    wire          dio;

    assign dio = host_low ? 1'b0 : 1'bz;
    pullup (dio);

    tm1638_responder #(.SYNC_STAGES(2)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_tm1638_clk(host_clk), .i_tm1638_stb(host_stb),
        .io_tm1638_data(dio), .i_key_bytes(i_key_bytes),
        .o_display_ram(o_display_ram), .o_wr_en(o_wr_en),
        .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_display_on(o_display_on), .o_brightness(o_brightness),
        .o_frame_err(o_frame_err), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    logic [11:0] wr_log [64] = '{default: '0};
    int          wr_total  = 0;
    int          err_total = 0;

    always @(negedge i_clk) begin
        if (o_wr_en) begin
            if (wr_total < 64) wr_log[wr_total] = {o_wr_addr, o_wr_data};
            wr_total++;
        end
        if (o_frame_err) err_total++;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            host_clk = 1'b0;
            host_low = ~b[i];
            wait_clk(HALF);
            host_clk = 1'b1;
            wait_clk(HALF);
        end
        host_low = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        host_clk = 1'b0;
        wait_clk(HALF);
        b = dio;
        host_clk = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic frame_begin();
        host_stb = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic frame_end();
        host_stb = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic frame1(input logic [7:0] b);
        frame_begin();
        send_bits(b, 8);
        frame_end();
    endtask

    function automatic logic [7:0] ram_byte(input logic [127:0] r, input logic [3:0] a);
        return r[a*8 +: 8];
    endfunction

    typedef struct {
        logic [7:0] pre;
        logic [7:0] acmd;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [11:0] w0;
        logic [11:0] w1;
        logic [3:0] ca;
        logic [7:0] cv;
        logic [3:0] cb;
        logic [7:0] cbv;
    } wvec_t;

    wvec_t vecs [3];

    initial begin
        int          base;
        logic        b;
        logic [7:0]  rd;
        logic [7:0]  exp_rd [4];

        vecs[0] = '{pre: 8'h40, acmd: 8'hC0, d0: 8'h3F, d1: 8'h06, w0: 12'h03F, w1: 12'h106,
                    ca: 4'h0, cv: 8'h3F, cb: 4'h1, cbv: 8'h06};
        vecs[1] = '{pre: 8'h44, acmd: 8'hC5, d0: 8'hAA, d1: 8'h55, w0: 12'h5AA, w1: 12'h555,
                    ca: 4'h5, cv: 8'h55, cb: 4'h6, cbv: 8'h00};
        vecs[2] = '{pre: 8'h40, acmd: 8'hCF, d0: 8'h11, d1: 8'h22, w0: 12'hF11, w1: 12'h022,
                    ca: 4'hF, cv: 8'h11, cb: 4'h0, cbv: 8'h22};

        wait_clk(5);
        check("rst_ram", o_display_ram, '0);
        check("rst_disp", {o_display_on, o_brightness}, 4'h0);
        check("rst_pulses", {o_wr_en, o_frame_err, o_busy}, 3'b000);
        check("rst_dio", dio, 1'b1);
        i_rst = 1'b0;
        wait_clk(HALF);

        for (int k = 0; k < 3; k++) begin
            base = wr_total;
            frame1(vecs[k].pre);
            frame_begin();
            send_bits(vecs[k].acmd, 8);
            send_bits(vecs[k].d0, 8);
            send_bits(vecs[k].d1, 8);
            frame_end();
            check($sformatf("v%0d_wr_count", k), wr_total - base, 2);
            check($sformatf("v%0d_wr0", k), wr_log[base], vecs[k].w0);
            check($sformatf("v%0d_wr1", k), wr_log[base + 1], vecs[k].w1);
            check($sformatf("v%0d_ram_a", k), ram_byte(o_display_ram, vecs[k].ca), vecs[k].cv);
            check($sformatf("v%0d_ram_b", k), ram_byte(o_display_ram, vecs[k].cb), vecs[k].cbv);
            if (k == 0) check("ram_lo16", o_display_ram[15:0], 16'h063F);
        end

        frame1(8'h8C);
        check("disp_8C", {o_display_on, o_brightness}, 4'b1100);
        frame1(8'h80);
        check("disp_80", {o_display_on, o_brightness}, 4'b0000);

        i_key_bytes = 32'h0401_0080;
        exp_rd = '{8'h80, 8'h00, 8'h01, 8'h04};
        frame_begin();
        send_bits(8'h42, 8);
        check("busy_in_frame", o_busy, 1'b1);
        for (int by = 0; by < 4; by++) begin
            rd = '0;
            for (int bi = 0; bi < 8; bi++) begin
                read_bit(b);
                rd[bi] = b;
            end
            check($sformatf("key_byte%0d", by), rd, exp_rd[by]);
        end
        check("dio_after_32", dio, 1'b1);
        frame_end();
        check("dio_after_stb", dio, 1'b1);
        check("busy_after_frame", o_busy, 1'b0);

        base = wr_total;
        frame_begin();
        send_bits(8'hC2, 8);
        send_bits(8'hFF, 3);
        frame_end();
        wait_clk(2);
        check("frame_err_count", err_total, 1);
        check("partial_no_write", wr_total - base, 0);
        check("partial_ram2", ram_byte(o_display_ram, 4'h2), 8'h00);

        frame_begin();
        send_bits(8'h42, 8);
        for (int i = 0; i < 4; i++) read_bit(b);
        host_clk = 1'b0;
        wait_clk(HALF);
        check("dio_driven_low", dio, 1'b0);
        i_rst = 1'b1;
        #1;
        check("rst_mid_dio", dio, 1'b1);
        check("rst_mid_ram", o_display_ram, '0);
        host_stb = 1'b1;
        host_clk = 1'b1;
        wait_clk(4);
        i_rst = 1'b0;
        wait_clk(HALF);

        base = wr_total;
        frame1(8'h40);
        frame_begin();
        send_bits(8'hC3, 8);
        send_bits(8'h5A, 8);
        send_bits(8'h5B, 8);
        frame_end();
        check("post_rst_count", wr_total - base, 2);
        check("post_rst_wr0", wr_log[base], 12'h35A);
        check("post_rst_wr1", wr_log[base + 1], 12'h45B);
        check("post_rst_ram", o_display_ram[39:24], 16'h5B5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
